// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - word-addressed data-memory responder with
// byte-lane writes, configurable wait states and valid/ready request/response channels.
module riscv_dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [3:0]  REQ_WSTRB,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_mem [DEPTH];

    logic [31:0]   w_word;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_accept;

    // Shifting the whole address keeps the range test exact over all 32 bits.
    assign w_word   = REQ_ADDR >> 2;
    assign w_oor    = (w_word >= 32'(DEPTH));
    assign w_idx    = w_word[AW-1:0];
    assign w_accept = (r_state == S_IDLE) && REQ_VALID;

    assign REQ_READY = r_req_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;

    // Storage is not reset; a write commits at its acceptance edge and survives a later reset.
    always_ff @(posedge CLK) begin
        if (!RST && w_accept && REQ_WE && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (REQ_WSTRB[i]) begin
                    r_mem[w_idx][8*i +: 8] <= REQ_WDATA[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_wait_cnt  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        r_req_ready <= 1'b0;
                        r_rsp_err   <= w_oor;
                        r_rsp_rdata <= (REQ_WE || w_oor) ? 32'd0 : r_mem[w_idx];
                        if (LATENCY == 0) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // Ready returns only after the handshake, leaving one idle bubble.
                    if (RSP_READY) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb/tb_riscv_dmem_responder.sv - scoreboard bench for riscv_dmem_responder
// (LATENCY=2 instance for functional tests, LATENCY=0 instance for back-to-back).
module tb_riscv_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        CLK;
    logic        RST;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_wstrb;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wstrb;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int checks   = 0;
    int failures = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] ma [1024];
    logic [31:0] mb [1024];

    riscv_dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready), .REQ_WE(a_req_we),
        .REQ_ADDR(a_req_addr), .REQ_WDATA(a_req_wdata), .REQ_WSTRB(a_req_wstrb),
        .RSP_VALID(a_rsp_valid), .RSP_READY(a_rsp_ready),
        .RSP_RDATA(a_rsp_rdata), .RSP_ERR(a_rsp_err)
    );

    riscv_dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready), .REQ_WE(b_req_we),
        .REQ_ADDR(b_req_addr), .REQ_WDATA(b_req_wdata), .REQ_WSTRB(b_req_wstrb),
        .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready),
        .RSP_RDATA(b_rsp_rdata), .RSP_ERR(b_rsp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t model_a(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        e.err = (addr >= 32'h1000);
        e.rdata = 32'd0;
        if (we) begin
            if (!e.err)
                for (int i = 0; i < 4; i++)
                    if (wstrb[i]) ma[addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
        end else if (!e.err) begin
            e.rdata = ma[addr[11:2]];
        end
        return e;
    endfunction

    function automatic exp_t model_b(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        e.err = (addr >= 32'h1000);
        e.rdata = 32'd0;
        if (we) begin
            if (!e.err)
                for (int i = 0; i < 4; i++)
                    if (wstrb[i]) mb[addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
        end else if (!e.err) begin
            e.rdata = mb[addr[11:2]];
        end
        return e;
    endfunction

    // Drives one request on the LATENCY=2 instance; starts and ends just after a falling edge.
    task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output int lat, output logic [31:0] rd,
                         output logic err, output bit ok);
        int t;
        ok = 1'b0; lat = 0; rd = 32'd0; err = 1'b0;
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
        a_req_wdata = wdata; a_req_wstrb = wstrb;
        t = 0;
        while (!a_req_ready && t < 20) begin @(negedge CLK); t++; end
        if (!a_req_ready) begin a_req_valid = 1'b0; return; end
        q_a.push_back(model_a(we, addr, wdata, wstrb));
        @(negedge CLK);
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 40) begin @(negedge CLK); lat++; end
        if (!a_rsp_valid) return;
        rd = a_rsp_rdata; err = a_rsp_err; ok = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_a: got rdy=%b vld=%b rd=%h err=%b exp rdy=1 vld=0 rd=0 err=0",
                     a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        checks++;
        if ({b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_b: got rdy=%b vld=%b rd=%h err=%b exp rdy=1 vld=0 rd=0 err=0",
                     b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_write_read;
        logic [31:0] wr[4]; logic [31:0] wa[4]; logic wwe[4];
        int lat; logic [31:0] rd; logic err; bit ok; exp_t e;
        wr = '{32'h0BADF00D, 32'h30303030, 32'hDEADBEEF, 32'h0};
        wa = '{32'h0, 32'h30, 32'h10, 32'h10};
        wwe = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_a(wwe[i], wa[i], wr[i], 4'b1111, lat, rd, err, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL wr_rd_timeout: req %0d got no response", i); continue; end
            e = q_a.pop_front();
            checks++;
            if (lat !== 3) begin failures++; $display("FAIL wr_rd_latency: got %0d exp 3", lat); end
            checks++;
            if ({rd, err} !== {e.rdata, e.err}) begin
                failures++;
                $display("FAIL wr_rd_rsp: got rd=%h err=%b exp rd=%h err=%b", rd, err, e.rdata, e.err);
            end
            @(negedge CLK);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_value: got %h exp deadbeef", rd); end
    endtask

    task automatic test_strobes;
        int lat; logic [31:0] rd; logic err; bit ok; exp_t e;
        run_a(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, lat, rd, err, ok);
        if (ok) void'(q_a.pop_front());
        @(negedge CLK);
        run_a(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, err, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL strobe_timeout: no response"); return; end
        e = q_a.pop_front();
        checks++;
        if ({rd, err} !== {e.rdata, e.err}) begin
            failures++;
            $display("FAIL strobe_rsp: got rd=%h err=%b exp rd=%h err=%b", rd, err, e.rdata, e.err);
        end
        checks++;
        if (rd !== 32'hDEBBBEDD) begin failures++; $display("FAIL strobe_value: got %h exp debbbedd", rd); end
        @(negedge CLK);
        run_a(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, err, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL nostrobe_timeout: no response"); return; end
        e = q_a.pop_front();
        checks++;
        if ({rd, err} !== {e.rdata, e.err}) begin
            failures++;
            $display("FAIL nostrobe_rsp: got rd=%h err=%b exp rd=%h err=%b", rd, err, e.rdata, e.err);
        end
        @(negedge CLK);
    endtask

    task automatic test_out_of_range;
        logic [31:0] ad[5]; logic [31:0] dt[5]; logic we[5];
        int lat; logic [31:0] rd; logic err; bit ok; exp_t e;
        ad = '{32'h1000, 32'h1000, 32'h0, 32'hFFC, 32'hFFC};
        dt = '{32'h55555555, 32'h0, 32'h0, 32'h13579BDF, 32'h0};
        we = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_a(we[i], ad[i], dt[i], 4'b1111, lat, rd, err, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL oor_timeout: req %0d got no response", i); continue; end
            e = q_a.pop_front();
            checks++;
            if ({rd, err} !== {e.rdata, e.err}) begin
                failures++;
                $display("FAIL oor_rsp%0d: got rd=%h err=%b exp rd=%h err=%b", i, rd, err, e.rdata, e.err);
            end
            if (i == 2) begin
                checks++;
                if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL oor_word0: got %h exp 0badf00d", rd); end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] rd; logic err; bit ok; exp_t e;
        a_rsp_ready = 1'b0;
        run_a(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, err, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_timeout: no response"); a_rsp_ready = 1'b1; return; end
        e = q_a.pop_front();
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h30;
        a_req_wdata = 32'hFFFFFFFF; a_req_wstrb = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready} !== {1'b1, e.rdata, e.err, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d: got vld=%b rd=%h err=%b rdy=%b exp vld=1 rd=%h err=%b rdy=0",
                         c, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready, e.rdata, e.err);
            end
            @(negedge CLK);
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if ({a_req_ready, a_rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL bp_release: got rdy=%b vld=%b exp rdy=1 vld=0", a_req_ready, a_rsp_valid);
        end
        run_a(1'b0, 32'h30, 32'h0, 4'b0000, lat, rd, err, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_ignored_timeout: no response"); return; end
        e = q_a.pop_front();
        checks++;
        if (rd !== 32'h30303030 || rd !== e.rdata) begin
            failures++;
            $display("FAIL bp_ignored_req: got %h exp 30303030", rd);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_in_wait;
        int lat; logic [31:0] rd; logic err; bit ok; exp_t e;
        checks++;
        if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rst_pre_ready: got %b exp 1", a_req_ready); end
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20;
        a_req_wdata = 32'h12345678; a_req_wstrb = 4'b1111;
        void'(model_a(1'b1, 32'h20, 32'h12345678, 4'b1111));
        @(negedge CLK);
        a_req_valid = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({a_rsp_valid, a_req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rst_wait_state: got vld=%b rdy=%b exp vld=0 rdy=1", a_rsp_valid, a_req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++;
            if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_no_rsp%0d: got vld=%b exp 0", c, a_rsp_valid); end
        end
        run_a(1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, err, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_read_timeout: no response"); return; end
        e = q_a.pop_front();
        checks++;
        if ({rd, err} !== {32'h12345678, 1'b0} || rd !== e.rdata) begin
            failures++;
            $display("FAIL rst_write_kept: got rd=%h err=%b exp rd=12345678 err=0", rd, err);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        logic [31:0] ad[8]; logic [31:0] dt[8]; logic we[8];
        int acc_cyc[8]; int n_acc; int n_rsp; bit acc; exp_t e;
        ad = '{32'h0, 32'h4, 32'h8, 32'hFFC, 32'h4, 32'hFFC, 32'h0, 32'h8};
        dt = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 32'h0, 32'h0, 32'h0, 32'h0};
        we = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        n_acc = 0; n_rsp = 0;
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_we = we[0]; b_req_addr = ad[0];
        b_req_wdata = dt[0]; b_req_wstrb = 4'b1111;
        for (int c = 0; c < 60 && n_rsp < 8; c++) begin
            acc = 1'b0;
            checks++;
            if (b_req_ready && b_rsp_valid) begin failures++; $display("FAIL b2b_ready_and_valid: cycle %0d", c); end
            if (b_rsp_valid) begin
                e = q_b.pop_front();
                checks++;
                if ({b_rsp_rdata, b_rsp_err} !== {e.rdata, e.err}) begin
                    failures++;
                    $display("FAIL b2b_rsp%0d: got rd=%h err=%b exp rd=%h err=%b",
                             n_rsp, b_rsp_rdata, b_rsp_err, e.rdata, e.err);
                end
                checks++;
                if (c - acc_cyc[n_rsp] !== 1) begin
                    failures++;
                    $display("FAIL b2b_latency%0d: got %0d exp 1", n_rsp, c - acc_cyc[n_rsp]);
                end
                n_rsp++;
            end
            if (b_req_ready && b_req_valid) begin
                q_b.push_back(model_b(b_req_we, b_req_addr, b_req_wdata, b_req_wstrb));
                acc_cyc[n_acc] = c;
                if (n_acc > 0) begin
                    checks++;
                    if (c - acc_cyc[n_acc-1] !== 2) begin
                        failures++;
                        $display("FAIL b2b_interval%0d: got %0d exp 2", n_acc, c - acc_cyc[n_acc-1]);
                    end
                end
                n_acc++;
                acc = 1'b1;
            end
            @(negedge CLK);
            if (acc) begin
                if (n_acc < 8) begin
                    b_req_we = we[n_acc]; b_req_addr = ad[n_acc]; b_req_wdata = dt[n_acc];
                end else begin
                    b_req_valid = 1'b0;
                end
            end
        end
        b_req_valid = 1'b0;
        checks++;
        if (n_rsp !== 8) begin failures++; $display("FAIL b2b_count: got %0d responses exp 8", n_rsp); end
    endtask

    initial begin
        RST = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'd0; a_req_wdata = 32'd0;
        a_req_wstrb = 4'd0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
        b_req_wstrb = 4'd0; b_rsp_ready = 1'b1;
        @(negedge CLK);
        test_reset;
        test_write_read;
        test_strobes;
        test_out_of_range;
        test_backpressure;
        test_reset_in_wait;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
